// File: rtl/wait_state_gen.sv
// ============================================================================
//  Module      : wait_state_gen
//  Description : READY generator for the CPU ready-control stage. Inserts a
//                parameterised number of wait cycles on reads to up to two
//                slow address windows, flags writes to those windows, and
//                provides a hold/DMA handshake. Acknowledges the hold once
//                rdy shows the CPU has halted.
//                Optional macro WAIT_STATS_EN adds a saturating count of
//                inserted wait cycles, output on wait_total.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wait_state_gen #(
    parameter logic [15:0] SLOW0_BASE = 16'hC000,
    parameter logic [15:0] SLOW0_MASK = 16'hF000,
    parameter int unsigned SLOW0_WAIT = 2,
    parameter logic [15:0] SLOW1_BASE = 16'hD000,
    parameter logic [15:0] SLOW1_MASK = 16'hF800,
    parameter int unsigned SLOW1_WAIT = 4,
    parameter int unsigned WAIT_W     = 4
) (
    input  logic        clk_2,
    input  logic        res_n,
    input  logic [15:0] addr,
    input  logic        rw_n,
    input  logic        rdy,
    input  logic        hold_req,
    output logic        READY,
    output logic        hold_ack,
    output logic        slow_write
`ifdef WAIT_STATS_EN
    ,
    output logic [15:0] wait_total
`endif
);

    // Wait counts truncated to the counter width; the caller keeps them in range.
    localparam logic [WAIT_W-1:0] WAIT0 = WAIT_W'(SLOW0_WAIT);
    localparam logic [WAIT_W-1:0] WAIT1 = WAIT_W'(SLOW1_WAIT);
    localparam logic              EN0   = (SLOW0_WAIT != 0);
    localparam logic              EN1   = (SLOW1_WAIT != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state;
    logic [WAIT_W-1:0] cnt;

    logic              hit0;
    logic              hit1;
    logic              hit;
    logic [WAIT_W-1:0] cnt_load;

    // Window decode; window 0 wins when both match.
    always_comb begin
        hit0     = ((addr & SLOW0_MASK) == SLOW0_BASE) && EN0;
        hit1     = ((addr & SLOW1_MASK) == SLOW1_BASE) && EN1;
        hit      = hit0 | hit1;
        cnt_load = hit0 ? (WAIT0 - 1'b1) : (WAIT1 - 1'b1);
    end

    // Main FSM: all outputs registered, READY low for exactly W posedges per slow read.
    always_ff @(posedge clk_2 or negedge res_n) begin
        if (!res_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            READY      <= 1'b1;
            hold_ack   <= 1'b0;
            slow_write <= 1'b0;
        end else begin
            slow_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hold_req) begin
                        state <= S_HOLD;
                        READY <= 1'b0;
                    end else if (rw_n && hit) begin
                        state <= S_WAIT;
                        READY <= 1'b0;
                        cnt   <= cnt_load;
                    end else if (!rw_n && hit) begin
                        slow_write <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        READY <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // The repeated access completes here; no decode, so no retrigger.
                    state <= S_IDLE;
                end
                S_HOLD: begin
                    if (!hold_req) begin
                        READY    <= 1'b1;
                        hold_ack <= 1'b0;
                        state    <= S_IDLE;
                    end else if (!rdy) begin
                        hold_ack <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    READY <= 1'b1;
                end
            endcase
        end
    end

`ifdef WAIT_STATS_EN
    logic [15:0] wait_total_q;

    // Saturating count of inserted wait cycles; hold cycles are excluded.
    always_ff @(posedge clk_2 or negedge res_n) begin
        if (!res_n) begin
            wait_total_q <= 16'h0000;
        end else if ((state == S_WAIT) && !READY && (wait_total_q != 16'hFFFF)) begin
            wait_total_q <= wait_total_q + 16'h0001;
        end
    end

    assign wait_total = wait_total_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wait_state_gen.sv
// ============================================================================
//  Module      : tb_wait_state_gen
//  Description : Directed self-checking bench for wait_state_gen.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wait_state_gen;

    logic        clk_2;
    logic        res_n;
    logic [15:0] addr;
    logic        rw_n;
    logic        rdy;
    logic        hold_req;
    logic        READY;
    logic        hold_ack;
    logic        slow_write;
`ifdef WAIT_STATS_EN
    logic [15:0] wait_total;
`endif

    int n_cmp = 0;
    int n_err = 0;

    wait_state_gen dut (
        .clk_2      (clk_2),
        .res_n      (res_n),
        .addr       (addr),
        .rw_n       (rw_n),
        .rdy        (rdy),
        .hold_req   (hold_req),
        .READY      (READY),
        .hold_ack   (hold_ack),
        .slow_write (slow_write)
`ifdef WAIT_STATS_EN
        ,
        .wait_total (wait_total)
`endif
    );

    initial clk_2 = 1'b0;
    always #5 clk_2 = ~clk_2;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance past the next posedge and settle.
    task automatic step();
        @(posedge clk_2);
        #1;
    endtask

    // Slow read lasting w wait cycles; ends back in IDLE.
    task automatic slow_read(input logic [15:0] a, input int w);
        addr = a;
        rw_n = 1'b1;
        step();
        addr = 16'h1234;
        for (int i = 0; i < w + 1; i++) step();
    endtask

    initial begin
        res_n    = 1'b0;
        addr     = 16'h1234;
        rw_n     = 1'b1;
        rdy      = 1'b1;
        hold_req = 1'b0;
        step();
        step();
        check("rst_ready", {15'd0, READY}, 16'd1);
        check("rst_ack",   {15'd0, hold_ack}, 16'd0);
        check("rst_sw",    {15'd0, slow_write}, 16'd0);
        res_n = 1'b1;

        // Fast read
        step();
        check("fast_ready", {15'd0, READY}, 16'd1);
        check("fast_sw",    {15'd0, slow_write}, 16'd0);
        check("fast_ack",   {15'd0, hold_ack}, 16'd0);

        // Window 0 read: 2 waits, repeated access in DONE gets no extra wait
        addr = 16'hC010;
        step();
        check("w0_k",    {15'd0, READY}, 16'd0);
        step();
        check("w0_k1",   {15'd0, READY}, 16'd0);
        step();
        check("w0_k2",   {15'd0, READY}, 16'd1);
        step();
        check("w0_done", {15'd0, READY}, 16'd1);
        addr = 16'h1234;
        step();
        check("w0_idle", {15'd0, READY}, 16'd1);

        // Window 1 read at top of window: 4 waits
        addr = 16'hD7FF;
        step();
        addr = 16'h1234;
        check("w1_0", {15'd0, READY}, 16'd0);
        for (int i = 1; i < 4; i++) begin
            step();
            check("w1_n", {15'd0, READY}, 16'd0);
        end
        step();
        check("w1_rise", {15'd0, READY}, 16'd1);
        step();
        check("w1_idle", {15'd0, READY}, 16'd1);

        // Address just past window 1 is fast
        addr = 16'hD800;
        step();
        check("d800_ready", {15'd0, READY}, 16'd1);

        // Slow write: no stall, one-cycle flag
        addr = 16'hC000;
        rw_n = 1'b0;
        step();
        check("sw_pulse", {15'd0, slow_write}, 16'd1);
        check("sw_ready", {15'd0, READY}, 16'd1);
        addr = 16'h1234;
        rw_n = 1'b1;
        step();
        check("sw_clear", {15'd0, slow_write}, 16'd0);

        // Hold during write: no ack while rdy=1
        rw_n     = 1'b0;
        hold_req = 1'b1;
        step();
        check("hw_ready", {15'd0, READY}, 16'd0);
        check("hw_ack0",  {15'd0, hold_ack}, 16'd0);
        step();
        check("hw_ack1",  {15'd0, hold_ack}, 16'd0);
        rw_n = 1'b1;
        rdy  = 1'b0;
        step();
        check("hw_ack",   {15'd0, hold_ack}, 16'd1);
        check("hw_ready2", {15'd0, READY}, 16'd0);
        hold_req = 1'b0;
        step();
        check("hw_rel_ready", {15'd0, READY}, 16'd1);
        check("hw_rel_ack",   {15'd0, hold_ack}, 16'd0);
        rdy = 1'b1;

        // Hold raised during WAIT: all waits complete, DONE, then HOLD
        addr = 16'hD000;
        step();
        check("hwt_k", {15'd0, READY}, 16'd0);
        hold_req = 1'b1;
        addr     = 16'h1234;
        for (int i = 1; i < 4; i++) begin
            step();
            check("hwt_wait", {15'd0, READY}, 16'd0);
        end
        step();
        check("hwt_done", {15'd0, READY}, 16'd1);
        step();
        check("hwt_idle", {15'd0, READY}, 16'd1);
        step();
        check("hwt_hold", {15'd0, READY}, 16'd0);
        rdy = 1'b0;
        step();
        check("hwt_ack", {15'd0, hold_ack}, 16'd1);

        // Asynchronous reset mid-hold
        #2 res_n = 1'b0;
        #1;
        check("arst_ready", {15'd0, READY}, 16'd1);
        check("arst_ack",   {15'd0, hold_ack}, 16'd0);
        hold_req = 1'b0;
        rdy      = 1'b1;
        step();
        res_n = 1'b1;
        step();
        check("post_rst_ready", {15'd0, READY}, 16'd1);

`ifdef WAIT_STATS_EN
        check("stat_rst", wait_total, 16'd0);
        slow_read(16'hC000, 2);
        slow_read(16'hC000, 2);
        slow_read(16'hC000, 2);
        slow_read(16'hD000, 4);
        check("stat_total", wait_total, 16'd10);
        force dut.wait_total_q = 16'hFFFF;
        #1;
        release dut.wait_total_q;
        slow_read(16'hC000, 2);
        check("stat_sat", wait_total, 16'hFFFF);
`else
        slow_read(16'hC000, 2);
        check("plain_read_end", {15'd0, READY}, 16'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
